// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

  typedef logic [511:0] line_t;

  localparam int LINE_BYTES   = 64;
  localparam int OFFSET_W     = $clog2(LINE_BYTES);
  localparam int DEF_NUM_SETS = 64;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return 64 - OFFSET_W - $clog2(sets);
  endfunction

  localparam int DEF_INDEX_W = index_w(DEF_NUM_SETS);
  localparam int DEF_TAG_W   = tag_w(DEF_NUM_SETS);

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: combinational read, one synchronous write, valid+dirty clear on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int IDX_W    = index_w(NUM_SETS),
  parameter int TG_W     = tag_w(NUM_SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TG_W-1:0]  rd_tag,
  output line_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic [TG_W-1:0]  wr_tag,
  input  line_t            wr_data
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TG_W-1:0]     tag_mem  [NUM_SETS];
  line_t               data_mem [NUM_SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_valid;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Tag/data contents are meaningless once valid clears, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_unit.sv
// Blocking direct-mapped write-back/write-allocate L1 D-cache with a 512-bit line port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_unit
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          wenable,
  input  logic [63:0]   addr,
  output logic [63:0]   rdata,
  input  logic [63:0]   wdata,
  output logic          done,
  output logic          drequest,
  output logic          dwrenable,
  output logic [63:0]   daddr,
  input  line_t         drdata,
  output line_t         dwdata,
  input  logic          ddone
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int IDX_W = index_w(NUM_SETS);
  localparam int TG_W  = tag_w(NUM_SETS);

  state_t      state;
  logic [63:3] addr_q;
  logic [63:0] wdata_q;
  logic        wen_q;

  logic [IDX_W-1:0] idx;
  logic [TG_W-1:0]  tag;
  logic [2:0]       word;
  logic             rd_valid, rd_dirty, hit;
  logic [TG_W-1:0]  rd_tag;
  line_t            rd_data;
  logic             wr_en, wr_valid, wr_dirty;
  logic [TG_W-1:0]  wr_tag;
  line_t            wr_data;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr[2:0];
  assign idx  = addr_q[OFFSET_W +: IDX_W];
  assign tag  = addr_q[63 -: TG_W];
  assign word = addr_q[5:3];
  assign hit  = rd_valid && (rd_tag == tag);

  function automatic line_t merge_word(input line_t l, input logic [2:0] w, input logic [63:0] d);
    line_t r;
    r = l;
    r[{w, 6'b0} +: 64] = d;
    return r;
  endfunction

  dcache_array #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .TG_W(TG_W)) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (idx),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_valid = 1'b0;
    wr_dirty = 1'b0;
    wr_tag   = tag;
    wr_data  = rd_data;
    case (state)
      LOOKUP: if (hit && wen_q) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_dirty = 1'b1;
        wr_data  = merge_word(rd_data, word, wdata_q);
      end
      WRITEBACK: if (ddone) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_tag   = rd_tag;
      end
      // A store miss merges its word into the incoming line in the same write.
      FILL: if (drequest && ddone) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_dirty = wen_q;
        wr_data  = wen_q ? merge_word(drdata, word, wdata_q) : drdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      rdata     <= '0;
      drequest  <= 1'b0;
      dwrenable <= 1'b0;
      daddr     <= '0;
      dwdata    <= '0;
`ifdef DCACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          addr_q  <= addr[63:3];
          wen_q   <= wenable;
          wdata_q <= wdata;
          state   <= LOOKUP;
        end
        LOOKUP: begin
`ifdef DCACHE_STATS_EN
          if (hit) hit_count <= hit_count + 32'd1;
          else     miss_count <= miss_count + 32'd1;
`endif
          if (hit) begin
            done  <= 1'b1;
            rdata <= wen_q ? 64'd0 : rd_data[{word, 6'b0} +: 64];
            state <= IDLE;
          end else if (rd_valid && rd_dirty) begin
            drequest  <= 1'b1;
            dwrenable <= 1'b1;
            daddr     <= {rd_tag, idx, 6'b0};
            dwdata    <= rd_data;
            state     <= WRITEBACK;
          end else begin
            drequest  <= 1'b1;
            dwrenable <= 1'b0;
            daddr     <= {addr_q[63:6], 6'b0};
            dwdata    <= '0;
            state     <= FILL;
          end
        end
        WRITEBACK: if (ddone) begin
          drequest  <= 1'b0;
          dwrenable <= 1'b0;
          state     <= FILL;
        end
        // Entered from WRITEBACK with drequest low: raise the fill request one cycle later.
        FILL: begin
          if (!drequest) begin
            drequest  <= 1'b1;
            dwrenable <= 1'b0;
            daddr     <= {addr_q[63:6], 6'b0};
            dwdata    <= '0;
          end else if (ddone) begin
            drequest <= 1'b0;
            daddr    <= '0;
            done     <= 1'b1;
            rdata    <= wen_q ? 64'd0 : drdata[{word, 6'b0} +: 64];
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_unit.sv
// Bench for dcache_unit: vector table with an rdata scoreboard, a line-memory arbiter model, and reset/late-ddone sequences.
module tb_dcache_unit;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, wenable, done, drequest, dwrenable, ddone;
  logic [63:0] addr, wdata, rdata, daddr;
  line_t       drdata, dwdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_unit dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .wenable   (wenable),
    .addr      (addr),
    .rdata     (rdata),
    .wdata     (wdata),
    .done      (done),
    .drequest  (drequest),
    .dwrenable (dwrenable),
    .daddr     (daddr),
    .drdata    (drdata),
    .dwdata    (dwdata),
    .ddone     (ddone)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    int          exp_ntxn;
    logic [63:0] exp_wb;
    logic [63:0] exp_fill;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    line_t       data;
  } txn_t;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  txn_t        txns[$];
  line_t       mem[logic [63:0]];
  line_t       last_wb;
  vec_t        vecs[10];

  function automatic line_t get_line(input logic [63:0] la);
    line_t l;
    if (mem.exists(la)) return mem[la];
    for (int k = 0; k < 8; k++) l[64*k +: 64] = {la[31:0], k[31:0]};
    return l;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic run_access(input vec_t v, input string name);
    int          cyc, reqc, cnt, lat;
    bit          got;
    logic [63:0] first_addr, expv;
    cyc = 0; reqc = 0; cnt = 0; lat = 0; got = 0; first_addr = '0;
    txns.delete();
    @(negedge clk);
    enable = 1'b1; wenable = v.we; addr = v.addr; wdata = v.wdata;
    exp_q.push_back(v.exp_rdata);
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      addr    = {$urandom, $urandom};
      wdata   = {$urandom, $urandom};
      wenable = ~v.we;
      if (ddone) ddone = 1'b0;
      if (done) begin
        got = 1; lat = cyc; enable = 1'b0;
        expv = exp_q.pop_front();
        check({name, " rdata"}, rdata, expv);
      end else if (drequest) begin
        reqc++; cnt++;
        if (cnt == 1) first_addr = daddr;
        if (cnt == 2) begin
          check({name, " daddr stable"}, daddr, first_addr);
          txns.push_back(txn_t'{dwrenable, daddr, dwdata});
          if (dwrenable) begin
            mem[daddr] = dwdata;
            last_wb    = dwdata;
          end else begin
            drdata = get_line(daddr);
          end
          ddone = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
      enable = 1'b0; ddone = 1'b0;
      exp_q.delete();
    end
    if (v.exp_lat != 0) check({name, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({name, " txn count"}, 64'(txns.size()), 64'(v.exp_ntxn));
    check({name, " no-request on hit"}, 64'(reqc == 0), 64'(v.exp_ntxn == 0));
    if (v.exp_wb != 0 && txns.size() >= 1) begin
      check({name, " wb dwrenable"}, 64'(txns[0].we), 64'd1);
      check({name, " wb daddr"}, txns[0].addr, v.exp_wb);
    end
    if (v.exp_fill != 0 && txns.size() >= 1) begin
      check({name, " fill dwrenable"}, 64'(txns[txns.size()-1].we), 64'd0);
      check({name, " fill daddr"}, txns[txns.size()-1].addr, v.exp_fill);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t l;
    vec_t  v;
    bit    saw_done;
    reset = 1'b1; enable = 1'b0; wenable = 1'b0; addr = '0; wdata = '0;
    ddone = 1'b0; drdata = '0; last_wb = '0;

    l = '0; l[64 +: 64] = 64'hDEADBEEF; mem[64'h1000] = l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = 64'h2000_0000_0000_0000 + 64'(k);
    mem[64'h2000] = l;
    mem[64'h3000] = '1;

    repeat (3) @(negedge clk);
    check("reset done", 64'(done), 64'd0);
    check("reset rdata", rdata, 64'd0);
    check("reset drequest", 64'(drequest), 64'd0);
    check("reset dwrenable", 64'(dwrenable), 64'd0);
    check("reset daddr", daddr, 64'd0);
    check("reset dwdata", 64'(|dwdata), 64'd0);
    reset = 1'b0;

    //          we  addr      wdata   exp_rdata               ntxn wb        fill      lat
    vecs[0] = '{1'b0, 64'h1008, 64'h0,  64'hDEADBEEF,          1, 64'h0,    64'h1000, 4};
    vecs[1] = '{1'b0, 64'h1008, 64'h0,  64'hDEADBEEF,          0, 64'h0,    64'h0,    2};
    vecs[2] = '{1'b1, 64'h1010, 64'h1234, 64'h0,               0, 64'h0,    64'h0,    2};
    vecs[3] = '{1'b0, 64'h1010, 64'h0,  64'h1234,              0, 64'h0,    64'h0,    2};
    vecs[4] = '{1'b0, 64'h2000, 64'h0,  64'h2000_0000_0000_0000, 2, 64'h1000, 64'h2000, 7};
    vecs[5] = '{1'b1, 64'h3018, 64'hAA, 64'h0,                 1, 64'h0,    64'h3000, 4};
    vecs[6] = '{1'b0, 64'h1008, 64'h0,  64'hDEADBEEF,          2, 64'h3000, 64'h1000, 7};
    vecs[7] = '{1'b0, 64'h1048, 64'h0,  64'h0000_1040_0000_0001, 1, 64'h0,  64'h1040, 4};
    vecs[8] = '{1'b1, 64'h1048, 64'h55, 64'h0,                 0, 64'h0,    64'h0,    2};
    vecs[9] = '{1'b0, 64'h1048, 64'h0,  64'h55,                0, 64'h0,    64'h0,    2};

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i], $sformatf("vec%0d", i));
      if (i == 4) begin
        check("evict 0x1000 word2", last_wb[128 +: 64], 64'h1234);
        check("evict 0x1000 word1", last_wb[64 +: 64], 64'hDEADBEEF);
      end
      if (i == 6) begin
        l = '1; l[192 +: 64] = 64'hAA;
        for (int k = 0; k < 8; k++)
          check($sformatf("evict 0x3000 word%0d", k), last_wb[64*k +: 64], l[64*k +: 64]);
      end
    end

    // Reset in the middle of a fill: request drops, no completion, contents invalidated.
    @(negedge clk);
    enable = 1'b1; wenable = 1'b0; addr = 64'h4000;
    repeat (2) @(negedge clk);
    check("mid-fill drequest up", 64'(drequest), 64'd1);
    check("mid-fill daddr", daddr, 64'h4000);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("reset drops drequest", 64'(drequest), 64'd0);
    check("reset no done", 64'(done), 64'd0);
    check("reset clears daddr", daddr, 64'd0);
    reset = 1'b0;
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("post-reset no done", 64'(saw_done), 64'd0);
    v = '{1'b0, 64'h1008, 64'h0, 64'hDEADBEEF, 1, 64'h0, 64'h1000, 4};
    run_access(v, "post-reset reload");

    // Stray ddone while idle is ignored.
    @(negedge clk);
    drdata = '1; ddone = 1'b1;
    @(negedge clk);
    ddone = 1'b0;
    check("late ddone done", 64'(done), 64'd0);
    check("late ddone drequest", 64'(drequest), 64'd0);
    @(negedge clk);
    check("late ddone done+1", 64'(done), 64'd0);
    v = '{1'b0, 64'h1008, 64'h0, 64'hDEADBEEF, 0, 64'h0, 64'h0, 2};
    run_access(v, "after late ddone");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_unit.md
Name: dcache_unit

Overview:
Blocking, single-ported L1 data cache between the core's MEM stage and the memory arbiter. It serves one aligned 64-bit load or store at a time. It is direct-mapped, write-back and write-allocate, with 64-byte lines. Misses, dirty evictions and fills use the arbiter's 512-bit line interface.

Parameters:
NUM_SETS, 64, number of direct-mapped lines (power of two); default gives 4 KiB capacity.
LINE_BYTES, 64, line size; fixed to match the 512-bit arbiter data path.

Ports:
clk  in  1  core clock, rising-edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  access request; held high until done.
wenable  in  1  1 = store, 0 = load; sampled with enable.
addr  in  64  byte address; addr[2:0] ignored (8-byte-aligned access).
rdata  out  64  load data, valid in done cycle.
wdata  in  64  store data, sampled with enable.
done  out  1  one-cycle completion pulse.
drequest  out  1  line request to arbiter.
dwrenable  out  1  1 = line write-back, 0 = line fill.
daddr  out  64  line address, low 6 bits zero.
drdata  in  512  fill data, valid when ddone.
dwdata  out  512  write-back line data.
ddone  in  1  arbiter completion pulse.

Behaviour:
- Address split: offset = addr[5:0]; word = addr[5:3]; index = addr[6+log2(NUM_SETS)-1:6]; tag = remaining upper bits. Word w occupies line bits [64w+63:64w] (little-endian).
- Per line storage: valid, dirty, tag, 512-bit data.
- States:
  - IDLE: enable=1 latches addr, wenable and wdata, then goes to LOOKUP.
  - LOOKUP: on hit, completes (see done rules) and returns to IDLE. On miss with victim valid and dirty, goes to WRITEBACK. Otherwise goes to FILL.
  - WRITEBACK: drequest=1, dwrenable=1, daddr={victim tag, index, 6'b0}, dwdata=victim line; all held until ddone. On ddone the line's dirty bit clears and state goes to FILL.
  - FILL: drequest=1, dwrenable=0, daddr={latched addr[63:6], 6'b0}; held until ddone. On ddone the line is written from drdata with valid=1, dirty=0, new tag, then completes.
- Completion: done=1 for exactly one cycle.
  - Load: rdata = selected word.
  - Store: selected word replaced by latched wdata, dirty=1, rdata = 0.
  - Next state IDLE.
- Hit latency: done in the 2nd cycle after enable is first sampled (IDLE→LOOKUP→done).
- Miss latency: LOOKUP + arbiter time(s) + 1 cycle.
- Caller deasserts enable in the cycle after it sees done; if enable is still high in IDLE, a new access starts.
- Changes to addr, wdata or wenable while busy are ignored.
- ddone outside WRITEBACK/FILL is ignored. drequest drops in the cycle after ddone.
- A store miss allocates first, then merges wdata into the filled line.
- Reset (at any time, including mid-miss):
  - State returns to IDLE; all valid and dirty bits clear; data/tag contents are don't-care.
  - All outputs 0: done, rdata, drequest, dwrenable, daddr, dwdata.
  - An in-flight arbiter transaction is abandoned with no done pulse.
- Outputs are registered; dwdata and daddr are stable while drequest=1.

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds outputs hit_count[31:0] and miss_count[31:0]. Each increments once per access at the LOOKUP decision, wraps at 2^32, and clears on reset.
- Undefined: these ports and counters do not exist; other behaviour is identical.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, LOOKUP, WRITEBACK, FILL};
  - line_t (512-bit) typedef;
  - LINE_BYTES constant;
  - index/tag width localparams derived from NUM_SETS.
- Sub-module dcache_array holds valid/dirty/tag/data storage. It provides a combinational read port and a single synchronous write port with clear-all on reset.

Test Plan:
- Cold load 0x1008 → FILL at daddr 0x1000 (dwrenable=0). Return drdata word1=0xDEADBEEF → done with rdata=0xDEADBEEF. Repeat load → hit, done 2 cycles after enable, drequest never asserted.
- Store 0x1010 data 0x1234 → store hit, done. Load 0x1010 → rdata 0x1234 with no arbiter traffic.
- Load 0x2000 (same index 0, different tag) after dirty 0x1000 → WRITEBACK daddr=0x1000 whose dwdata word2=0x1234, then FILL daddr=0x2000, then done.
- Store miss to 0x3018 data 0xAA → FILL 0x3000 with drdata all 0xFF. Later eviction writes back a line with word3=0xAA and all other bytes 0xFF.
- Reset asserted during FILL, before ddone → drequest=0 next cycle, no done. Following load to same address misses again.
- Late ddone: assert ddone while IDLE → no state change, no done.
